// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative MULTU/DIVU.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   start, alu_op, a, b   request and operands, sampled on accept
//   busy                  MULTU/DIVU iteration in progress
//   done                  one-cycle completion pulse
//   result/zero/overflow  registered result and flags
//   hi/lo                 high word/remainder and low word/quotient
module alu_multicycle #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MULU = 3'b011;
  localparam logic [2:0] OP_DIVU = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  logic [1:0]       r_state,  w_state_nxt;
  logic [CW-1:0]    r_cnt,    w_cnt_nxt;
  logic [WIDTH-1:0] r_acc_hi, w_acc_hi_nxt;
  logic [WIDTH-1:0] r_acc_lo, w_acc_lo_nxt;
  logic [WIDTH-1:0] r_opb,    w_opb_nxt;
  logic             r_busy,   w_busy_nxt;
  logic             r_done,   w_done_nxt;
  logic [WIDTH-1:0] r_result, w_result_nxt;
  logic             r_zero,   w_zero_nxt;
  logic             r_ovf,    w_ovf_nxt;
  logic [WIDTH-1:0] r_hi,     w_hi_nxt;
  logic [WIDTH-1:0] r_lo,     w_lo_nxt;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_ovf;

  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_hi;
  logic [WIDTH-1:0] w_mul_lo;
  logic [WIDTH:0]   w_div_sh;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_diff;
  logic [WIDTH-1:0] w_div_hi;
  logic [WIDTH-1:0] w_div_lo;
  logic             w_last;

  assign w_sum  = a + b;
  assign w_diff = a - b;

  // Single-cycle datapath
  always_comb begin
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    case (alu_op)
      OP_AND: w_alu_res = a & b;
      OP_OR:  w_alu_res = a | b;
      OP_ADD: begin
        w_alu_res = w_sum;
        w_alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu_res = w_diff;
        w_alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      // Direct signed compare stays correct when a-b overflows
      OP_SLT: w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: w_alu_res = '0;
    endcase
  end

  // Shift-add step: conditionally add multiplicand, shift {carry,hi,lo} right
  assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opb} : '0);
  assign w_mul_hi  = w_mul_sum[WIDTH:1];
  assign w_mul_lo  = {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};

  // Restoring division step; divisor 0 naturally yields all-ones quotient, remainder a
  assign w_div_sh   = {r_acc_hi, r_acc_lo[WIDTH-1]};
  assign w_div_ge   = (w_div_sh >= {1'b0, r_opb});
  assign w_div_diff = WIDTH'(w_div_sh - {1'b0, r_opb});
  assign w_div_hi   = w_div_ge ? w_div_diff : w_div_sh[WIDTH-1:0];
  assign w_div_lo   = {r_acc_lo[WIDTH-2:0], w_div_ge};

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // Next-state and output logic
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_acc_hi_nxt = r_acc_hi;
    w_acc_lo_nxt = r_acc_lo;
    w_opb_nxt    = r_opb;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_result_nxt = r_result;
    w_zero_nxt   = r_zero;
    w_ovf_nxt    = r_ovf;
    w_hi_nxt     = r_hi;
    w_lo_nxt     = r_lo;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (alu_op == OP_MULU || alu_op == OP_DIVU) begin
            w_state_nxt  = (alu_op == OP_MULU) ? S_MUL : S_DIV;
            w_cnt_nxt    = '0;
            w_acc_hi_nxt = '0;
            w_acc_lo_nxt = a;
            w_opb_nxt    = b;
            w_busy_nxt   = 1'b1;
          end else begin
            w_result_nxt = w_alu_res;
            w_zero_nxt   = (w_alu_res == '0);
            w_ovf_nxt    = w_alu_ovf;
            w_done_nxt   = 1'b1;
          end
        end
      end
      S_MUL, S_DIV: begin
        w_acc_hi_nxt = (r_state == S_MUL) ? w_mul_hi : w_div_hi;
        w_acc_lo_nxt = (r_state == S_MUL) ? w_mul_lo : w_div_lo;
        w_cnt_nxt    = r_cnt + CW'(1);
        if (w_last) begin
          w_hi_nxt     = w_acc_hi_nxt;
          w_lo_nxt     = w_acc_lo_nxt;
          w_result_nxt = w_acc_lo_nxt;
          w_zero_nxt   = (w_acc_lo_nxt == '0);
          w_ovf_nxt    = 1'b0;
          w_busy_nxt   = 1'b0;
          w_done_nxt   = 1'b1;
          w_cnt_nxt    = '0;
          w_state_nxt  = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_opb    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_acc_hi <= w_acc_hi_nxt;
      r_acc_lo <= w_acc_lo_nxt;
      r_opb    <= w_opb_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_result <= w_result_nxt;
      r_zero   <= w_zero_nxt;
      r_ovf    <= w_ovf_nxt;
      r_hi     <= w_hi_nxt;
      r_lo     <= w_lo_nxt;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign result   = r_result;
  assign zero     = r_zero;
  assign overflow = r_ovf;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle (WIDTH=32).
module tb_alu_multicycle;

  localparam int unsigned W = 32;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MULU = 3'b011;
  localparam logic [2:0] OP_DIVU = 3'b100;
  localparam logic [2:0] OP_RSV  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic [2:0]   alu_op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         zero;
  logic         overflow;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_cmp = 0;
  int n_err = 0;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .alu_op   (alu_op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .zero     (zero),
    .overflow (overflow),
    .hi       (hi),
    .lo       (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a request; called at a negedge so it is seen by the next rising edge
  task automatic drive(input logic [2:0] op, input logic [W-1:0] va, input logic [W-1:0] vb);
    start  = 1'b1;
    alu_op = op;
    a      = va;
    b      = vb;
  endtask

  // Single-cycle op: drive, step past the accept edge, drop start
  task automatic single(input logic [2:0] op, input logic [W-1:0] va, input logic [W-1:0] vb);
    drive(op, va, vb);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Long op already driven: step past accept, then count cycles until busy drops
  task automatic wait_long(output int cyc);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  int cyc;
  int done_cnt;

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    alu_op  = 3'b000;
    a       = '0;
    b       = '0;

    repeat (3) @(negedge clk);
    check("rst_busy",   64'(busy), 64'd0);
    check("rst_done",   64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_zero",   64'(zero), 64'd0);
    check("rst_ovf",    64'(overflow), 64'd0);
    check("rst_hi",     64'(hi), 64'd0);
    check("rst_lo",     64'(lo), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // ADD signed overflow
    single(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    check("add_res",  64'(result), 64'h8000_0000);
    check("add_ovf",  64'(overflow), 64'd1);
    check("add_zero", 64'(zero), 64'd0);
    check("add_done", 64'(done), 64'd1);
    check("add_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("add_done_1cyc", 64'(done), 64'd0);

    // SUB to zero
    single(OP_SUB, 32'd5, 32'd5);
    check("sub_res",  64'(result), 64'd0);
    check("sub_zero", 64'(zero), 64'd1);
    check("sub_ovf",  64'(overflow), 64'd0);

    // SUB signed overflow: min - 1
    single(OP_SUB, 32'h8000_0000, 32'h0000_0001);
    check("subov_res", 64'(result), 64'h7FFF_FFFF);
    check("subov_ovf", 64'(overflow), 64'd1);

    // SLT across overflowing difference
    single(OP_SLT, 32'h8000_0000, 32'h0000_0001);
    check("slt1_res", 64'(result), 64'd1);
    check("slt1_ovf", 64'(overflow), 64'd0);
    single(OP_SLT, 32'h0000_0001, 32'h8000_0000);
    check("slt0_res",  64'(result), 64'd0);
    check("slt0_zero", 64'(zero), 64'd1);
    check("slt0_ovf",  64'(overflow), 64'd0);

    // Reserved op
    single(OP_ADD, 32'd1, 32'd2);
    single(OP_RSV, 32'h1234, 32'h5678);
    check("rsv_res",  64'(result), 64'd0);
    check("rsv_zero", 64'(zero), 64'd1);
    check("rsv_done", 64'(done), 64'd1);

    single(OP_AND, 32'h0000_F0F0, 32'h0000_FF00);
    check("and_res", 64'(result), 64'h0000_F000);
    single(OP_OR, 32'h0000_F0F0, 32'h0000_FF00);
    check("or_res",  64'(result), 64'h0000_FFF0);
    check("or_ovf",  64'(overflow), 64'd0);
    check("single_hi_untouched", 64'(hi), 64'd0);
    check("single_lo_untouched", 64'(lo), 64'd0);

    // MULTU with an ADD request injected while busy
    drive(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    start = 1'b0;
    check("mul_busy_start", 64'(busy), 64'd1);
    check("mul_done_start", 64'(done), 64'd0);
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      if (cyc == 3) drive(OP_ADD, 32'd1, 32'd1);
      else start = 1'b0;
      @(negedge clk);
      cyc++;
      if (cyc == 5) begin
        check("mul_hold_result", 64'(result), 64'h0000_FFF0);
        check("mul_mid_hi",      64'(hi), 64'd0);
        check("mul_mid_lo",      64'(lo), 64'd0);
      end
    end
    start = 1'b0;
    check("mul_cycles", 64'(cyc), 64'd32);
    check("mul_done",   64'(done), 64'd1);
    check("mul_hi",     64'(hi), 64'hFFFF_FFFE);
    check("mul_lo",     64'(lo), 64'h0000_0001);
    check("mul_res",    64'(result), 64'h0000_0001);
    check("mul_zero",   64'(zero), 64'd0);
    @(negedge clk);
    check("mul_done_1cyc", 64'(done), 64'd0);

    // Single-cycle op leaves hi/lo alone
    single(OP_ADD, 32'd2, 32'd3);
    check("add2_res", 64'(result), 64'd5);
    check("add2_hi",  64'(hi), 64'hFFFF_FFFE);
    check("add2_lo",  64'(lo), 64'h0000_0001);

    // DIVU 100/7, then back-to-back DIVU 5/0 issued in the done cycle
    drive(OP_DIVU, 32'd100, 32'd7);
    wait_long(cyc);
    check("div_cycles", 64'(cyc), 64'd32);
    check("div_done",   64'(done), 64'd1);
    check("div_lo",     64'(lo), 64'd14);
    check("div_hi",     64'(hi), 64'd2);
    check("div_res",    64'(result), 64'd14);
    drive(OP_DIVU, 32'd5, 32'd0);
    @(negedge clk);
    check("b2b_busy", 64'(busy), 64'd1);
    check("b2b_done", 64'(done), 64'd0);
    start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("div0_cycles", 64'(cyc), 64'd32);
    check("div0_lo",     64'(lo), 64'hFFFF_FFFF);
    check("div0_hi",     64'(hi), 64'd5);
    check("div0_ovf",    64'(overflow), 64'd0);

    // Reset 10 cycles into MULTU aborts it immediately
    drive(OP_MULU, 32'd3, 32'd5);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_busy",   64'(busy), 64'd0);
    check("abort_hi",     64'(hi), 64'd0);
    check("abort_lo",     64'(lo), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);
    check("abort_idle",    64'(busy), 64'd0);

    // First accept after reset
    single(OP_ADD, 32'd2, 32'd3);
    check("post_rst_res",  64'(result), 64'd5);
    check("post_rst_done", 64'(done), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal values 4..64.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; accepted on a rising edge when busy==0.
REQ-005 alu_op  input  3  operation select, sampled with start.
REQ-006 a  input  WIDTH  operand A, sampled with start.
REQ-007 b  input  WIDTH  operand B, sampled with start.
REQ-008 busy  output  1  high while a MULTU/DIVU iteration is in progress.
REQ-009 done  output  1  one-cycle pulse: operation complete, outputs valid.
REQ-010 result  output  WIDTH  registered result.
REQ-011 zero  output  1  registered result==0.
REQ-012 overflow  output  1  registered signed overflow flag.
REQ-013 hi  output  WIDTH  high word / remainder register.
REQ-014 lo  output  WIDTH  low word / quotient register.

Function
REQ-015 Op encoding: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed), 011 MULTU, 100 DIVU, 101 reserved.
REQ-016 FSM states IDLE, MUL, DIV; IDLE on reset.
REQ-017 Accept edge = rising edge with start==1 and busy==0 (including the cycle done is high); start at any other time is ignored.
REQ-018 AND/OR/ADD/SUB/SLT: result, zero, overflow updated on the accept edge; done high for the following cycle; FSM stays IDLE (latency 1).
REQ-019 ADD/SUB: result = (a +/- b) mod 2^WIDTH; overflow = two's-complement signed overflow.
REQ-020 SLT: result = 1 if signed a < signed b else 0, correct even when a-b overflows; overflow = 0.
REQ-021 AND/OR: bitwise; overflow = 0.
REQ-022 Reserved op: result = 0, zero = 1, overflow = 0, done pulses as in REQ-018.
REQ-023 MULTU/DIVU: accept edge loads operands, clears iteration counter, enters MUL/DIV, sets busy=1.
REQ-024 Exactly WIDTH iterations, one per subsequent edge; at iteration WIDTH, hi/lo written, result=lo, zero=(lo==0), overflow=0, busy=0, done=1 for one cycle, FSM to IDLE.
REQ-025 Busy therefore lasts exactly WIDTH cycles; done appears WIDTH cycles after the accept edge.
REQ-026 MULTU: unsigned shift-add; {hi,lo} = a*b (2*WIDTH bits, no truncation).
REQ-027 DIVU: unsigned restoring division; lo = a/b, hi = a%b.
REQ-028 DIVU with b==0: lo = all ones, hi = a; same latency; no other flag.
REQ-029 hi/lo change only at MULTU/DIVU completion; result/zero/overflow hold their previous values while busy.
REQ-030 Single-cycle ops never modify hi/lo.
REQ-031 Intermediate iteration state is internal; hi/lo not updated mid-operation.

Reset
REQ-032 reset_n low forces immediately: FSM IDLE, busy=0, done=0, result=0, zero=0, overflow=0, hi=0, lo=0, counter=0.
REQ-033 Reset mid MULTU/DIVU aborts the operation; no done pulse is produced for it.
REQ-034 First accept edge is the first rising edge with reset_n high and start high.

Verification (WIDTH=32)
REQ-035 ADD a=0x7FFFFFFF b=0x00000001 -> next cycle result=0x80000000, overflow=1, zero=0, done=1 for one cycle; SUB a=5 b=5 -> result=0, zero=1, overflow=0.
REQ-036 SLT a=0x80000000 b=0x00000001 -> result=1; SLT a=0x00000001 b=0x80000000 -> result=0; overflow=0 both.
REQ-037 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy high 32 cycles, then hi=0xFFFFFFFE, lo=0x00000001, result=0x00000001, done one cycle.
REQ-038 DIVU a=100 b=7 -> after 32 cycles lo=14, hi=2; DIVU a=5 b=0 -> lo=0xFFFFFFFF, hi=5.
REQ-039 start with ADD asserted during MULTU busy -> ignored, result unchanged until MULTU done; start held high in done cycle -> next op accepted on that edge.
REQ-040 reset_n low 10 cycles into MULTU -> busy=0, hi=lo=0, result=0 immediately; no done pulse in following 40 cycles with start=0.
